afu_mmio_csr_responder: RTL and testbench
=========================================

// Module: afu_mmio_csr_responder
// PURPOSE
//  AFU-side responder for host-initiated CCI-P MMIO traffic. Decodes MMIO write/read requests (CfgHdr_t).
//  Holds a bank of 64-bit CSRs and returns read responses tagged with the request tid through a buffered response queue.
//  Sits between the emulator's MMIO request channel and the AFU's MMIO response channel; the CSR outputs feed AFU logic.
// PARAMETERS
//  NUM_CSR            16       number of 64-bit CSRs (power of 2, 2..64)
//  CSR_BASE_INDEX     16'h0010 DWORD index of CSR0; CSR k occupies DWORDs BASE+2k (lo), BASE+2k+1 (hi)
//  CSR0_RO_VALUE      64'h0    CSR0 is read-only and always reads this value
//  RSP_FIFO_LOG2      3        response FIFO depth = 2**RSP_FIFO_LOG2
// PORTS
//  clk            in   1          single clock
//  SoftReset      in   1          synchronous, active-high reset
//  mmio_wr_valid  in   1          MMIO write request this cycle
//  mmio_rd_valid  in   1          MMIO read request this cycle
//  mmio_hdr       in   28         CfgHdr_t {index[15:0], len[1:0], poison, tid[8:0]}; len 0=32b, 1=64b
//  mmio_wrdata    in   64         write data (32b writes use [31:0])
//  mmio_rsp_valid out  1          read response valid
//  mmio_rsp_tid   out  9          tid of the request being answered
//  mmio_rsp_data  out  64         read data
//  mmio_rsp_ready in   1          downstream accepts response (pop when valid&&ready)
//  csr_q          out  NUM_CSR*64 current CSR contents, CSR k at [64k+63:64k]
//  csr_wr_pulse   out  NUM_CSR    1-cycle pulse, cycle after CSR k is written
//  err_overflow   out  1          sticky: read dropped, response FIFO full
//  err_access     out  1          sticky: misaligned 64b, len>1, poisoned, or simultaneous rd+wr
// BEHAVIOUR
//  Reset: CSRs (except CSR0) = 0, FIFO empty, pipeline cleared, all outputs 0. In-flight reads are discarded and receive no response.
//  Decode: off = index - CSR_BASE_INDEX (16b, wraps); hit when off < 2*NUM_CSR; k = off>>1; half = off[0].
//  Write (accepted each cycle, no backpressure):
//   - 64b, half=0: CSR k <= wrdata.
//   - 32b: updates only the lo or hi half of CSR k, selected by half.
//   - CSR k updates at the edge ending the request cycle; csr_wr_pulse[k]=1 for the following cycle.
//   - Miss, or write to CSR0: ignored silently.
//   - Poison=1, len>1, or 64b with half=1: ignored and err_access set.
//  Read: 2-stage pipeline.
//   - S1 captures tid plus data as of the request cycle. A write in an earlier cycle is visible to the read.
//   - S2 pushes the response into the FIFO.
//   - Latency: mmio_rsp_valid asserts at minimum 2 cycles after mmio_rd_valid (FIFO empty).
//   - Read data: 64b hit -> CSR k. 32b hit -> {32'h0, selected half}. Miss -> 64'h0.
//   - Bad access (len>1, 64b with half=1, poison) -> 64'hFFFF_FFFF_FFFF_FFFF with err_access set; a response is always generated.
//  Simultaneous rd_valid && wr_valid: write performed, read dropped (no response), err_access set.
//  FIFO: first-word-fall-through, in-order.
//   - Push and pop in the same cycle are legal when full; count is unchanged.
//   - Push when full without pop: response dropped, err_overflow set, FIFO unchanged.
//   - rsp outputs hold stable while valid && !ready.
//  Error flags are sticky until SoftReset.
// TESTING
//  1. Write CSR3 64b (index 0x16, data 0xDEADBEEF_CAFEF00D), read index 0x16 tid 0x1A5 -> rsp at +2 cycles, tid 0x1A5, data 0xDEADBEEF_CAFEF00D; csr_wr_pulse[3] seen once.
//  2. 32b write 0x12345678 to index 0x17 on CSR3=0 -> CSR3=0x12345678_00000000; 32b read index 0x17 -> 0x00000000_12345678.
//  3. Hold mmio_rsp_ready=0, issue 9 reads (depth 8) -> 8 responses in tid order after ready=1, 9th dropped, err_overflow=1.
//  4. 64b read index 0x13 -> data all-ones, err_access=1. Read index 0x0100 -> data 0, no error. Write CSR0 -> reads CSR0_RO_VALUE.
//  5. rd+wr same cycle -> write lands, no response, err_access=1. SoftReset with 2 reads in flight -> no responses, all outputs 0.

Source files
------------

// File: rtl/afu_mmio_csr_responder.sv
// AFU MMIO responder: decodes host CSR writes/reads and answers reads with their tid.
// Latency: a write updates its CSR at the end of the request cycle. A read response appears 2 cycles after the request when the FIFO is empty.
// Backpressure: writes are never stalled. Reads queue in a response FIFO, and a read whose response finds the FIFO full is dropped.

// Small first-word-fall-through FIFO used for the read responses.
// Latency: a pushed entry becomes visible at the output one cycle after the push.
// Backpressure: a push into a full FIFO with no pop is refused and flagged on ovf.
module afu_rsp_fifo #(
  parameter int W    = 73,
  parameter int LOG2 = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic         ovf
);
  localparam logic [LOG2:0] DEPTH_C = (LOG2+1)'(1 << LOG2);

  logic [W-1:0]    mem_q [1 << LOG2];
  logic [LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [LOG2:0]   cnt_q;
  logic            full, pop, push_ok;

  assign full    = (cnt_q == DEPTH_C);
  assign out_vld = (cnt_q != '0);
  assign pop     = out_vld & out_rdy;
  // A pop in the same cycle makes room, so a full FIFO can still take a push.
  assign push_ok = in_vld & (~full | pop);
  assign ovf     = in_vld & full & ~pop;
  assign out_dat = mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (LOG2+1)'(push_ok) - (LOG2+1)'(pop);
    end
  end

  // Storage needs no reset because occupancy is what qualifies the data.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= in_dat;
  end
endmodule

module afu_mmio_csr_responder #(
  parameter int          NUM_CSR        = 16,
  parameter logic [15:0] CSR_BASE_INDEX = 16'h0010,
  parameter logic [63:0] CSR0_RO_VALUE  = 64'h0,
  parameter int          RSP_FIFO_LOG2  = 3
) (
  input  logic                   clk,
  input  logic                   SoftReset,
  input  logic                   mmio_wr_valid,
  input  logic                   mmio_rd_valid,
  input  logic [27:0]            mmio_hdr,
  input  logic [63:0]            mmio_wrdata,
  output logic                   mmio_rsp_valid,
  output logic [8:0]             mmio_rsp_tid,
  output logic [63:0]            mmio_rsp_data,
  input  logic                   mmio_rsp_ready,
  output logic [NUM_CSR*64-1:0]  csr_q,
  output logic [NUM_CSR-1:0]     csr_wr_pulse,
  output logic                   err_overflow,
  output logic                   err_access
);
  localparam int KW = $clog2(NUM_CSR);

  // Header fields: {index, len, poison, tid}.
  logic [15:0] hdr_index;
  logic [1:0]  hdr_len;
  logic        hdr_poison;
  logic [8:0]  hdr_tid;
  assign hdr_index  = mmio_hdr[27:12];
  assign hdr_len    = mmio_hdr[11:10];
  assign hdr_poison = mmio_hdr[9];
  assign hdr_tid    = mmio_hdr[8:0];

  // Offset from CSR0 wraps at 16 bits, so indices below the base read as misses.
  logic [15:0]   off;
  logic          hit, half, bad, wr_ok, rd_take;
  logic [KW-1:0] k_sel;
  assign off     = hdr_index - CSR_BASE_INDEX;
  assign hit     = (off < 16'(2 * NUM_CSR));
  assign k_sel   = off[KW:1];
  assign half    = off[0];
  assign bad     = hdr_poison | hdr_len[1] | (hdr_len[0] & half);
  assign wr_ok   = mmio_wr_valid & ~bad & hit & (k_sel != '0);
  // When a write and a read arrive together, the write wins and the read is dropped.
  assign rd_take = mmio_rd_valid & ~mmio_wr_valid;

  logic [63:0] csr_arr [NUM_CSR];

  // CSR0 is a constant; every other CSR is a register updated by decoded writes.
  assign csr_arr[0]   = CSR0_RO_VALUE;
  assign csr_q[63:0]  = CSR0_RO_VALUE;
  for (genvar k = 1; k < NUM_CSR; k++) begin : g_csr
    logic [63:0] r_q, r_d;
    logic        wr_this;
    assign wr_this = wr_ok & (k_sel == KW'(k));

    // Merge a 64-bit write or the selected 32-bit half into the current value.
    always_comb begin
      r_d = r_q;
      if (wr_this) begin
        if (hdr_len[0])  r_d = mmio_wrdata;
        else if (half)   r_d[63:32] = mmio_wrdata[31:0];
        else             r_d[31:0]  = mmio_wrdata[31:0];
      end
    end

    // Hold the CSR value.
    always_ff @(posedge clk) begin
      if (SoftReset) r_q <= '0;
      else           r_q <= r_d;
    end

    assign csr_arr[k]         = r_q;
    assign csr_q[64*k +: 64]  = r_q;
  end

  // Read data as of the request cycle.
  logic [63:0] csr_rd, rd_dat;
  assign csr_rd = csr_arr[k_sel];
  always_comb begin
    rd_dat = '0;
    if (bad)             rd_dat = '1;
    else if (!hit)       rd_dat = '0;
    else if (hdr_len[0]) rd_dat = csr_rd;
    else if (half)       rd_dat = {32'h0, csr_rd[63:32]};
    else                 rd_dat = {32'h0, csr_rd[31:0]};
  end

  logic [NUM_CSR-1:0] pulse_q, pulse_d;
  // One-hot pulse marking the CSR written in the previous cycle.
  always_comb begin
    pulse_d = '0;
    if (wr_ok) pulse_d[k_sel] = 1'b1;
  end

  logic        s1_vld_q;
  logic [8:0]  s1_tid_q;
  logic [63:0] s1_dat_q;
  logic        fifo_vld, fifo_ovf;
  logic [72:0] fifo_dat;
  logic        err_ov_q, err_ov_d, err_acc_q, err_acc_d;

  assign err_ov_d  = err_ov_q | fifo_ovf;
  assign err_acc_d = err_acc_q | ((mmio_wr_valid | mmio_rd_valid) & bad)
                   | (mmio_wr_valid & mmio_rd_valid);

  // First read stage captures the response. A reset also discards any read in flight.
  always_ff @(posedge clk) begin
    if (SoftReset) begin
      s1_vld_q  <= 1'b0;
      s1_tid_q  <= '0;
      s1_dat_q  <= '0;
      pulse_q   <= '0;
      err_ov_q  <= 1'b0;
      err_acc_q <= 1'b0;
    end else begin
      s1_vld_q  <= rd_take;
      if (rd_take) begin
        s1_tid_q <= hdr_tid;
        s1_dat_q <= rd_dat;
      end
      pulse_q   <= pulse_d;
      err_ov_q  <= err_ov_d;
      err_acc_q <= err_acc_d;
    end
  end

  // Second stage: the captured response is pushed into the FIFO.
  afu_rsp_fifo #(.W(73), .LOG2(RSP_FIFO_LOG2)) u_rsp_fifo (
    .clk     (clk),
    .rst     (SoftReset),
    .in_vld  (s1_vld_q),
    .in_dat  ({s1_tid_q, s1_dat_q}),
    .out_vld (fifo_vld),
    .out_rdy (mmio_rsp_ready),
    .out_dat (fifo_dat),
    .ovf     (fifo_ovf)
  );

  // Response fields read as zero while no response is valid.
  assign mmio_rsp_valid = fifo_vld;
  assign mmio_rsp_tid   = fifo_vld ? fifo_dat[72:64] : 9'h0;
  assign mmio_rsp_data  = fifo_vld ? fifo_dat[63:0]  : 64'h0;
  assign csr_wr_pulse   = pulse_q;
  assign err_overflow   = err_ov_q;
  assign err_access     = err_acc_q;
endmodule

// File: tb/tb_afu_mmio_csr_responder.sv
// Bench for afu_mmio_csr_responder: a transaction-level model plus directed and random traffic.
// Every cycle, all DUT outputs are compared with the model 1 ns after the rising edge.
// The model treats responses as timestamped queue entries; the FIFO is a plain queue.
module tb_afu_mmio_csr_responder;
  localparam int          N     = 16;
  localparam logic [15:0] BASE  = 16'h0010;
  localparam logic [63:0] RO    = 64'hA5A5_0000_1234_5678;
  localparam int          LOG2  = 3;
  localparam int          DEPTH = 1 << LOG2;

  logic           clk;
  logic           SoftReset, mmio_wr_valid, mmio_rd_valid, mmio_rsp_ready;
  logic [27:0]    mmio_hdr;
  logic [63:0]    mmio_wrdata;
  logic           mmio_rsp_valid;
  logic [8:0]     mmio_rsp_tid;
  logic [63:0]    mmio_rsp_data;
  logic [N*64-1:0] csr_q;
  logic [N-1:0]   csr_wr_pulse;
  logic           err_overflow, err_access;

  afu_mmio_csr_responder #(
    .NUM_CSR(N), .CSR_BASE_INDEX(BASE), .CSR0_RO_VALUE(RO), .RSP_FIFO_LOG2(LOG2)
  ) dut (
    .clk(clk), .SoftReset(SoftReset),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_hdr(mmio_hdr), .mmio_wrdata(mmio_wrdata),
    .mmio_rsp_valid(mmio_rsp_valid), .mmio_rsp_tid(mmio_rsp_tid),
    .mmio_rsp_data(mmio_rsp_data), .mmio_rsp_ready(mmio_rsp_ready),
    .csr_q(csr_q), .csr_wr_pulse(csr_wr_pulse),
    .err_overflow(err_overflow), .err_access(err_access)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [8:0] tid; logic [63:0] dat; int pc; } pend_t;
  typedef struct { logic [8:0] tid; logic [63:0] dat; } rsp_t;

  pend_t       pend[$];   // captured reads waiting for their FIFO push cycle
  rsp_t        fq[$];     // responses visible to the host, oldest first
  logic [63:0] m_csr [N];
  logic [N-1:0] m_pulse;
  bit          m_ov, m_acc;
  int          cyc_n = 0;
  int          nvec = 0, nerr = 0;

  function automatic logic [27:0] hdr(input logic [15:0] idx, input logic [1:0] len,
                                      input logic poison, input logic [8:0] tid);
    return {idx, len, poison, tid};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: got %h want %h", name, cyc_n, act, exp);
    end
  endtask

  task automatic model_reset();
    pend.delete();
    fq.delete();
    for (int k = 0; k < N; k++) m_csr[k] = 64'h0;
    m_csr[0] = RO;
    m_pulse  = '0;
    m_ov     = 0;
    m_acc    = 0;
  endtask

  task automatic check_all();
    if (fq.size() > 0) begin
      chk("rsp_valid", 64'(mmio_rsp_valid), 64'd1);
      chk("rsp_tid",   64'(mmio_rsp_tid),   64'(fq[0].tid));
      chk("rsp_data",  mmio_rsp_data,       fq[0].dat);
    end else begin
      chk("rsp_valid", 64'(mmio_rsp_valid), 64'd0);
      chk("rsp_tid",   64'(mmio_rsp_tid),   64'd0);
      chk("rsp_data",  mmio_rsp_data,       64'd0);
    end
    chk("err_overflow", 64'(err_overflow), 64'(m_ov));
    chk("err_access",   64'(err_access),   64'(m_acc));
    chk("csr_wr_pulse", 64'(csr_wr_pulse), 64'(m_pulse));
    for (int k = 0; k < N; k++)
      chk($sformatf("csr%0d", k), csr_q[k*64 +: 64], m_csr[k]);
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic cyc(input bit rst, input bit wr, input bit rd, input logic [27:0] h,
                     input logic [63:0] d, input bit rdy);
    logic [15:0] off;
    int          k;
    bit          hit, half, bad, pop, full;
    logic [63:0] v, rdat;
    logic [N-1:0] np;
    SoftReset      = rst;
    mmio_wr_valid  = wr;
    mmio_rd_valid  = rd;
    mmio_hdr       = h;
    mmio_wrdata    = d;
    mmio_rsp_ready = rdy;
    if (rst) begin
      model_reset();
    end else begin
      pop  = (fq.size() > 0) && rdy;
      full = (fq.size() == DEPTH);
      if (pop) void'(fq.pop_front());
      if (pend.size() > 0 && pend[0].pc == cyc_n) begin
        if (full && !pop) m_ov = 1;
        else fq.push_back('{tid: pend[0].tid, dat: pend[0].dat});
        void'(pend.pop_front());
      end
      off  = h[27:12] - BASE;
      hit  = (int'(off) < 2 * N);
      k    = int'(off) / 2;
      half = off[0];
      bad  = h[9] || (h[11:10] > 2'd1) || (h[11:10] == 2'd1 && half);
      rdat = 64'h0;
      if (bad) rdat = {64{1'b1}};
      else if (hit) begin
        v = m_csr[k];
        if (h[11:10] == 2'd1) rdat = v;
        else rdat = half ? {32'h0, v[63:32]} : {32'h0, v[31:0]};
      end
      if (rd && !wr) pend.push_back('{tid: h[8:0], dat: rdat, pc: cyc_n + 1});
      if ((rd || wr) && bad) m_acc = 1;
      if (rd && wr) m_acc = 1;
      np = '0;
      if (wr && !bad && hit && k != 0) begin
        if (h[11:10] == 2'd1) m_csr[k] = d;
        else if (half)        m_csr[k][63:32] = d[31:0];
        else                  m_csr[k][31:0]  = d[31:0];
        np[k] = 1'b1;
      end
      m_pulse = np;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    cyc(0, 0, 0, 28'h0, 64'h0, rdy);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 28'h0, 64'h0, 1);
    cyc(1, 0, 0, 28'h0, 64'h0, 1);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset rsp_valid", 64'(mmio_rsp_valid), 64'd0);
    chk("reset csr3", csr_q[3*64 +: 64], 64'h0);
    chk("reset err_access", 64'(err_access), 64'd0);

    // 1: 64b write to CSR3, then read it back.
    cyc(0, 1, 0, hdr(16'h0016, 2'd1, 0, 9'h0), 64'hDEADBEEF_CAFEF00D, 1);
    chk("t1 pulse", 64'(csr_wr_pulse), 64'h8);
    chk("t1 csr3", csr_q[3*64 +: 64], 64'hDEADBEEF_CAFEF00D);
    cyc(0, 0, 1, hdr(16'h0016, 2'd1, 0, 9'h1A5), 64'h0, 1);
    chk("t1 pulse once", 64'(csr_wr_pulse), 64'h0);
    chk("t1 not yet", 64'(mmio_rsp_valid), 64'd0);
    idle(1);
    chk("t1 rsp_valid", 64'(mmio_rsp_valid), 64'd1);
    chk("t1 rsp_tid", 64'(mmio_rsp_tid), 64'h1A5);
    chk("t1 rsp_data", mmio_rsp_data, 64'hDEADBEEF_CAFEF00D);
    idle(1);

    // 2: 32b write to the high half of CSR3.
    cyc(0, 1, 0, hdr(16'h0016, 2'd1, 0, 9'h0), 64'h0, 1);
    cyc(0, 1, 0, hdr(16'h0017, 2'd0, 0, 9'h0), 64'hFFFF_FFFF_1234_5678, 1);
    chk("t2 csr3", csr_q[3*64 +: 64], 64'h12345678_00000000);
    cyc(0, 0, 1, hdr(16'h0017, 2'd0, 0, 9'h033), 64'h0, 1);
    idle(1);
    chk("t2 rsp_data", mmio_rsp_data, 64'h00000000_12345678);
    idle(1);

    // 3: nine reads with ready low; the ninth overflows.
    for (int i = 0; i < 9; i++) cyc(0, 0, 1, hdr(16'h0016, 2'd1, 0, 9'(i)), 64'h0, 0);
    idle(0);
    idle(0);
    chk("t3 err_overflow", 64'(err_overflow), 64'd1);
    for (int i = 0; i < 8; i++) begin
      chk("t3 rsp_valid", 64'(mmio_rsp_valid), 64'd1);
      chk("t3 tid order", 64'(mmio_rsp_tid), 64'(i));
      idle(1);
    end
    chk("t3 drained", 64'(mmio_rsp_valid), 64'd0);

    // 4: misaligned 64b read, miss read, write to read-only CSR0.
    do_reset();
    cyc(0, 0, 1, hdr(16'h0013, 2'd1, 0, 9'h005), 64'h0, 1);
    chk("t4 err_access", 64'(err_access), 64'd1);
    idle(1);
    chk("t4 bad data", mmio_rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
    do_reset();
    cyc(0, 0, 1, hdr(16'h0100, 2'd1, 0, 9'h006), 64'h0, 1);
    idle(1);
    chk("t4 miss valid", 64'(mmio_rsp_valid), 64'd1);
    chk("t4 miss data", mmio_rsp_data, 64'h0);
    chk("t4 miss no err", 64'(err_access), 64'd0);
    cyc(0, 1, 0, hdr(16'h0010, 2'd1, 0, 9'h0), 64'h1111_2222_3333_4444, 1);
    cyc(0, 0, 1, hdr(16'h0010, 2'd1, 0, 9'h007), 64'h0, 1);
    idle(1);
    chk("t4 csr0 ro", mmio_rsp_data, 64'hA5A5_0000_1234_5678);
    idle(1);

    // 5: read and write in the same cycle; reset with reads in flight.
    do_reset();
    cyc(0, 1, 1, hdr(16'h0018, 2'd1, 0, 9'h008), 64'h0BAD_F00D_0000_0004, 1);
    chk("t5 write lands", csr_q[4*64 +: 64], 64'h0BAD_F00D_0000_0004);
    chk("t5 err_access", 64'(err_access), 64'd1);
    idle(1);
    idle(1);
    chk("t5 no rsp", 64'(mmio_rsp_valid), 64'd0);
    cyc(0, 0, 1, hdr(16'h0018, 2'd1, 0, 9'h009), 64'h0, 0);
    cyc(0, 0, 1, hdr(16'h0018, 2'd1, 0, 9'h00A), 64'h0, 0);
    cyc(1, 0, 0, 28'h0, 64'h0, 1);
    idle(1);
    idle(1);
    chk("t5 rst rsp_valid", 64'(mmio_rsp_valid), 64'd0);
    chk("t5 rst csr4", csr_q[4*64 +: 64], 64'h0);
    chk("t5 rst err_access", 64'(err_access), 64'd0);

    // Random traffic with alternating phases of heavy and light backpressure.
    for (int c = 0; c < 3000; c++) begin
      automatic bit          rst  = ($urandom_range(0, 199) == 0);
      automatic bit          wr   = ($urandom_range(0, 99) < 30);
      automatic bit          rd   = ($urandom_range(0, 99) < 45);
      automatic int          rp   = ((c / 200) % 3 == 0) ? 10 : 70;
      automatic bit          rdy  = ($urandom_range(0, 99) < rp);
      automatic logic [15:0] idx;
      automatic logic [1:0]  len;
      automatic logic        poi  = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 9) < 8) idx = BASE + 16'($urandom_range(0, 2 * N + 3)) - 16'd2;
      else                          idx = 16'($urandom);
      if ($urandom_range(0, 9) == 0) len = 2'($urandom_range(2, 3));
      else                           len = 2'($urandom_range(0, 1));
      cyc(rst, wr, rd, hdr(idx, len, poi, 9'($urandom)), {$urandom, $urandom}, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
